// File: rtl/id_branch_stage_if.sv
// id_branch_stage_if: fetch-side inputs and decode/fetch-facing outputs of the IF/ID branch stage
interface id_branch_stage_if #(parameter int CNT_W = 16);
  logic             if_valid;
  logic [15:0]      instr;
  logic [15:0]      pc;
  logic [15:0]      pcplus1;
  logic             pred;
  logic             stall;
  logic [15:0]      rx_data;
  logic             t;
  logic             cond_ready;
  logic             id_valid;
  logic [15:0]      id_instr;
  logic [15:0]      id_pc;
  logic [15:0]      id_pcplus1;
  logic             isbranch;
  logic             stall_pc;
  logic             redirect;
  logic [15:0]      redirect_pc;
  logic             prewrong;
  logic             precorrc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  modport master (
    output if_valid, instr, pc, pcplus1, pred, stall, rx_data, t, cond_ready,
    input  id_valid, id_instr, id_pc, id_pcplus1, isbranch, stall_pc, redirect, redirect_pc,
           prewrong, precorrc, branch_cnt, mispred_cnt
  );
  modport slave (
    input  if_valid, instr, pc, pcplus1, pred, stall, rx_data, t, cond_ready,
    output id_valid, id_instr, id_pc, id_pcplus1, isbranch, stall_pc, redirect, redirect_pc,
           prewrong, precorrc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/id_branch_stage.sv
// id_branch_stage: IF/ID pipeline register that resolves branches in ID and drives fetch redirects
module id_branch_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  id_branch_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HELD, WAIT} state_t;
  state_t           state, state_nx;
  logic [15:0]      instr_q, pc_q, pc1_q;
  logic             pred_q;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  logic             id_valid, is_b, is_beqz, is_bnez, is_bt, branch;
  logic             taken, cond_ok, resolve, mispred, stall_pc;
  logic [15:0]      id_instr, imm, target;
  always_comb begin
    id_valid = state != EMPTY;
    id_instr = id_valid ? instr_q : NOP_INSTR;
    is_b     = id_instr[15:11] == 5'b00010;
    is_beqz  = id_instr[15:11] == 5'b00100;
    is_bnez  = id_instr[15:11] == 5'b00101;
    is_bt    = id_instr[15:11] == 5'b01100 && id_instr[10:9] == 2'b00;
    branch   = is_b | is_beqz | is_bnez | is_bt;
    imm      = is_b ? {{5{id_instr[10]}}, id_instr[10:0]} : {{8{id_instr[7]}}, id_instr[7:0]};
    target   = pc1_q + imm;
    taken    = is_b | (is_beqz & (bus.rx_data == 16'h0)) | (is_bnez & (bus.rx_data != 16'h0))
             | (is_bt & (bus.t == id_instr[8]));
    cond_ok  = is_b | bus.cond_ready;
    resolve  = id_valid & branch & cond_ok & ~bus.stall;
    // pred=1 means fall-through was chosen, so a mispredict is taken == pred
    mispred  = resolve & (taken == pred_q);
    stall_pc = bus.stall | (id_valid & branch & ~cond_ok);
    state_nx = mispred ? EMPTY
             : stall_pc ? (!id_valid ? EMPTY : (branch & ~cond_ok) ? WAIT : HELD)
             : bus.if_valid ? HELD : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc1_q   <= '0;
      pred_q  <= 1'b0;
    end else if (mispred) begin
      instr_q <= NOP_INSTR;
    end else if (!stall_pc) begin
      instr_q <= bus.instr;
      pc_q    <= bus.pc;
      pc1_q   <= bus.pcplus1;
      pred_q  <= bus.pred;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (resolve) begin
      branch_cnt  <= branch_cnt + CNT_W'(!(&branch_cnt));
      mispred_cnt <= mispred_cnt + CNT_W'(mispred && !(&mispred_cnt));
    end
  end
  assign bus.id_valid    = id_valid;
  assign bus.id_instr    = id_instr;
  assign bus.id_pc       = pc_q;
  assign bus.id_pcplus1  = pc1_q;
  assign bus.isbranch    = id_valid & branch;
  assign bus.stall_pc    = stall_pc;
  assign bus.redirect    = mispred;
  assign bus.redirect_pc = mispred ? (taken ? target : pc1_q) : 16'h0;
  assign bus.prewrong    = mispred;
  assign bus.precorrc    = resolve & ~mispred;
  assign bus.branch_cnt  = branch_cnt;
  assign bus.mispred_cnt = mispred_cnt;
endmodule

// File: tb/tb_id_branch_stage.sv
// tb_id_branch_stage: scoreboard bench comparing the stage against a branch-rule reference model
module tb_id_branch_stage;
  localparam logic [15:0] NOP = 16'h0800;
  logic clk = 0, rst = 1, rst2 = 1;
  always #5 clk = ~clk;
  id_branch_stage_if #(16) m ();
  id_branch_stage_if #(4)  sb ();
  id_branch_stage #(.NOP_INSTR(NOP), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(m));
  id_branch_stage #(.NOP_INSTR(NOP), .CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(sb));
  typedef struct {
    bit valid; logic [15:0] instr, pc, pc1;
    bit isb, stall_pc, res, redir; logic [15:0] rpc;
    bit wrong, corr; int bc, mc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit m_valid, m_pred;
  logic [15:0] m_instr, m_pc, m_pc1;
  int m_bc, m_mc;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic int kind_of(logic [15:0] i);
    case (i[15:11])
      5'b00010: return 1;
      5'b00100: return 2;
      5'b00101: return 3;
      5'b01100: return i[10:8] == 3'b000 ? 4 : i[10:8] == 3'b001 ? 5 : 0;
      default:  return 0;
    endcase
  endfunction
  function automatic exp_t predict(bit st, logic [15:0] rx, bit tt, bit cr);
    exp_t e;
    int k = m_valid ? kind_of(m_instr) : 0;
    int imm = k == 1 ? int'($signed(m_instr[10:0])) : int'($signed(m_instr[7:0]));
    int tgt = (int'(m_pc1) + imm) & 'hFFFF;
    bit tk = k == 1 || (k == 2 && rx == 0) || (k == 3 && rx != 0) || (k == 4 && !tt) || (k == 5 && tt);
    bit rdy = k == 1 || cr;
    e.valid = m_valid; e.instr = m_valid ? m_instr : NOP; e.pc = m_pc; e.pc1 = m_pc1;
    e.isb = k != 0;
    e.stall_pc = st || (k != 0 && !rdy);
    e.res = k != 0 && rdy && !st;
    e.redir = e.res && (tk != !m_pred);
    e.rpc = e.redir ? (tk ? 16'(tgt) : m_pc1) : 16'h0;
    e.wrong = e.redir; e.corr = e.res && !e.redir;
    e.bc = m_bc; e.mc = m_mc;
    return e;
  endfunction
  task automatic model_reset();
    m_valid = 0; m_pred = 0; m_instr = NOP; m_pc = 0; m_pc1 = 0; m_bc = 0; m_mc = 0;
  endtask
  task automatic step(input bit r, input bit v, input logic [15:0] ins, input logic [15:0] pc,
                      input bit pr, input bit st, input logic [15:0] rx, input bit tt, input bit cr);
    exp_t e;
    rst = r; m.if_valid = v; m.instr = ins; m.pc = pc; m.pcplus1 = pc + 16'h1; m.pred = pr;
    m.stall = st; m.rx_data = rx; m.t = tt; m.cond_ready = cr;
    e = predict(st, rx, tt, cr);
    q.push_back(e);
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (e.res) begin
        if (m_bc < 65535) m_bc++;
        if (e.redir && m_mc < 65535) m_mc++;
      end
      if (e.redir) m_valid = 0;
      else if (!e.stall_pc) begin
        m_valid = v; m_instr = ins; m_pc = pc; m_pc1 = pc + 16'h1; m_pred = pr;
      end
    end
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("id_valid", 32'(m.id_valid), 32'(e.valid));
      chk("id_instr", 32'(m.id_instr), 32'(e.instr));
      if (e.valid) begin
        chk("id_pc", 32'(m.id_pc), 32'(e.pc));
        chk("id_pcplus1", 32'(m.id_pcplus1), 32'(e.pc1));
      end
      chk("isbranch", 32'(m.isbranch), 32'(e.isb));
      chk("stall_pc", 32'(m.stall_pc), 32'(e.stall_pc));
      chk("redirect", 32'(m.redirect), 32'(e.redir));
      chk("redirect_pc", 32'(m.redirect_pc), 32'(e.rpc));
      chk("prewrong", 32'(m.prewrong), 32'(e.wrong));
      chk("precorrc", 32'(m.precorrc), 32'(e.corr));
      chk("branch_cnt", 32'(m.branch_cnt), 32'(e.bc));
      chk("mispred_cnt", 32'(m.mispred_cnt), 32'(e.mc));
    end
  end
  function automatic logic [15:0] rand_instr();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: return r;
      1: return {5'b00010, r[10:0]};
      2: return {5'b00100, r[10:0]};
      3: return {5'b00101, r[10:0]};
      4: return {5'b01100, 3'b000, r[7:0]};
      default: return {5'b01100, 3'b001, r[7:0]};
    endcase
  endfunction
  initial begin
    model_reset();
    m.if_valid = 0; m.instr = NOP; m.pc = 0; m.pcplus1 = 1; m.pred = 0;
    m.stall = 0; m.rx_data = 0; m.t = 0; m.cond_ready = 0;
    sb.if_valid = 0; sb.instr = 16'h1000; sb.pc = 0; sb.pcplus1 = 1; sb.pred = 0;
    sb.stall = 0; sb.rx_data = 0; sb.t = 0; sb.cond_ready = 0;
    // saturation on a narrow-counter instance: B with imm 0 every cycle
    repeat (2) @(posedge clk);
    #1 rst2 = 0; sb.if_valid = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sat_bc_partial", 32'(sb.branch_cnt), 32'd7);
    chk("sat_mc_partial", 32'(sb.mispred_cnt), 32'd0);
    chk("sat_precorrc", 32'(sb.precorrc), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_bc", 32'(sb.branch_cnt), 32'd15);
    sb.pred = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("sat_mc", 32'(sb.mispred_cnt), 32'd15);
    chk("sat_bc_hold", 32'(sb.branch_cnt), 32'd15);
    rst2 = 1;
    @(posedge clk);
    @(negedge clk);
    chk("sat_rst_bc", 32'(sb.branch_cnt), 32'd0);
    chk("sat_rst_mc", 32'(sb.mispred_cnt), 32'd0);
    chk("sat_rst_valid", 32'(sb.id_valid), 32'd0);
    @(posedge clk);
    #1;
    // directed scenarios
    step(1, 0, NOP, 0, 0, 0, 0, 0, 0);
    chk("rst_id_pc", 32'(m.id_pc), 32'd0);
    chk("rst_id_pcplus1", 32'(m.id_pcplus1), 32'd0);
    step(0, 1, 16'h4101, 16'h0005, 0, 0, 0, 0, 0);
    step(0, 1, 16'h1003, 16'h0010, 1, 0, 0, 0, 0);
    step(0, 1, 16'h4101, 16'h0011, 1, 0, 0, 0, 0);
    step(0, 1, 16'h21FE, 16'h0020, 0, 0, 0, 0, 1);
    step(0, 1, 16'h4101, 16'h001F, 0, 0, 16'h0000, 0, 1);
    step(0, 1, 16'h2805, 16'h0030, 0, 0, 0, 0, 0);
    step(0, 1, 16'h4101, 16'h0031, 1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h4101, 16'h0031, 1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h4101, 16'h0031, 1, 0, 16'h0000, 0, 1);
    step(0, 1, 16'h2002, 16'h0040, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h4101, 16'h0043, 1, 1, 16'h0000, 0, 1);
    step(0, 1, 16'h4101, 16'h0043, 1, 0, 16'h0000, 0, 1);
    step(0, 1, 16'h3004, 16'h0050, 0, 0, 0, 0, 0);
    step(0, 1, 16'h4101, 16'h0051, 1, 0, 16'h0000, 0, 0);
    step(1, 1, 16'h4101, 16'h0051, 1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h6101, 16'h0060, 1, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] pc = 16'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, rand_instr(), pc,
           1'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) ? 16'h0 : 16'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    step(0, 0, NOP, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
